// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite read slave: response codes and read FSM states.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } rd_state_t;

endpackage

// File: rtl/axi_lite_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the pointers wrap naturally.
module axi_lite_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi4_lite_read_slave_pipelined.sv
// AXI4-Lite read slave: queues read addresses, decodes a window, and serves hits from a
// req/ready/rvalid backend with a timeout; responses are registered and held until accepted.
//
// state | meaning
// IDLE  | waiting for a queued address; pops and decodes it
// REQ   | mem_req asserted, waiting for mem_ready
// WAIT  | backend accepted; waiting for mem_rvalid or timeout
// RESP  | RVALID asserted with held RDATA/RRESP until RREADY
module axi4_lite_read_slave_pipelined
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    AR_DEPTH       = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = ADDR_WIDTH'(32'h0000_1000),
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  mem_abort
);

  localparam int                CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit                TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

  rd_state_t               state, state_n;
  logic [CNT_W-1:0]        to_cnt, to_cnt_n;
  logic [ADDR_WIDTH-1:0]   mem_addr_n;
  logic [DATA_WIDTH-1:0]   rdata, rdata_n;
  resp_t                   rresp, rresp_n;

  logic                    ar_push, ar_pop, ar_full, ar_empty;
  logic [ADDR_WIDTH-1:0]   ar_head;
  logic [$clog2(AR_DEPTH):0] unused_ar_count;
  logic                    unused_prot;
  logic                    head_hit;
  logic                    timeout_hit;

  assign unused_prot   = ^S_AXI_ARPROT;
  assign S_AXI_ARREADY = ~ar_full;
  assign ar_push       = S_AXI_ARVALID & S_AXI_ARREADY;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

  // Extra top bit keeps the window compare correct when BASE+SPAN reaches the top of the map.
  assign head_hit    = ({1'b0, ar_head} >= WIN_LO) && ({1'b0, ar_head} < WIN_HI);
  assign timeout_hit = TO_EN && (to_cnt == TO_LAST);

  axi_lite_sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (AR_DEPTH)
  ) u_ar_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ar_push),
    .pop   (ar_pop),
    .din   (S_AXI_ARADDR),
    .dout  (ar_head),
    .full  (ar_full),
    .empty (ar_empty),
    .count (unused_ar_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      to_cnt   <= '0;
      mem_addr <= '0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      state    <= state_n;
      to_cnt   <= to_cnt_n;
      mem_addr <= mem_addr_n;
      rdata    <= rdata_n;
      rresp    <= rresp_n;
    end
  end

  always_comb begin
    state_n      = state;
    to_cnt_n     = to_cnt;
    mem_addr_n   = mem_addr;
    rdata_n      = rdata;
    rresp_n      = rresp;
    ar_pop       = 1'b0;
    mem_req      = 1'b0;
    mem_abort    = 1'b0;
    S_AXI_RVALID = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!ar_empty) begin
          ar_pop = 1'b1;
          if (head_hit) begin
            mem_addr_n = ar_head;
            state_n    = ST_REQ;
          end else begin
            rdata_n = '0;
            rresp_n = RESP_DECERR;
            state_n = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          to_cnt_n = '0;
          state_n  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Data arriving on the last allowed cycle beats the timeout.
        if (mem_rvalid) begin
          rdata_n = mem_rdata;
          rresp_n = RESP_OKAY;
          state_n = ST_RESP;
        end else if (timeout_hit) begin
          rdata_n   = '0;
          rresp_n   = RESP_SLVERR;
          mem_abort = 1'b1;
          state_n   = ST_RESP;
        end else if (TO_EN) begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_read_slave_pipelined.sv
// Directed and random reads against a queue-based model of the AXI read slave and its backend.
module tb_axi4_lite_read_slave_pipelined;

  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;

  logic        clk, rst_n;
  logic [31:0] S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        mem_req, mem_ready, mem_rvalid, mem_abort;
  logic [31:0] mem_addr, mem_rdata;

  axi4_lite_read_slave_pipelined #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .AR_DEPTH (2),
    .BASE_ADDR (BASE), .ADDR_SPAN (SPAN), .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .S_AXI_ARADDR (S_AXI_ARADDR), .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID), .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA (S_AXI_RDATA), .S_AXI_RRESP (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID), .S_AXI_RREADY (S_AXI_RREADY),
    .mem_req (mem_req), .mem_addr (mem_addr), .mem_ready (mem_ready),
    .mem_rdata (mem_rdata), .mem_rvalid (mem_rvalid), .mem_abort (mem_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; } exp_t;
  typedef struct { logic [31:0] addr; int lat; } hit_t;

  exp_t        exp_q[$];
  hit_t        hit_q[$];
  logic [31:0] ar_pend[$];
  int          plan_lat[$];
  int          acc_cyc[$];

  int n_assert = 0, n_fail = 0, cyc = 0;
  int ready_pct = 100, rready_pct = 100;
  bit junk_en = 1'b0;
  int be_phase = 0, be_wcnt = 0, be_lat = 0;
  logic [31:0] be_addr = '0;
  int n_abort = 0, n_req_cycles = 0, n_accepted = 0, n_resp = 0, last_lat = 0;
  logic prev_rv = 1'b0, prev_rr = 1'b0;
  logic [31:0] prev_rd = '0;
  logic [1:0]  prev_rs = '0;
  int base_acc, base_resp, base_abort, base_req;

  function automatic logic [31:0] datafn(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit in_window(logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + {1'b0, SPAN}));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of every agent: AR master, backend responder, R master, and the scoreboard.
  task automatic step();
    bit          give_rv, exp_abort;
    exp_t        e;
    hit_t        h;
    logic [31:0] a;
    int          lat;
    @(negedge clk);
    cyc++;
    S_AXI_ARVALID = (ar_pend.size() > 0);
    S_AXI_ARADDR  = 32'h0;
    if (S_AXI_ARVALID) S_AXI_ARADDR = ar_pend[0];
    S_AXI_ARPROT = 3'($urandom);
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    give_rv    = 1'b0;
    if (be_phase == 1) begin
      be_wcnt++;
      if (be_wcnt == be_lat) begin
        give_rv    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = datafn(be_addr);
      end
    end else begin
      if (mem_req) mem_ready = ($urandom_range(1, 100) <= ready_pct);
      if (junk_en && $urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
    end
    S_AXI_RREADY = ($urandom_range(1, 100) <= rready_pct);
    #1;
    exp_abort = (be_phase == 1) && (be_wcnt == TO) && !give_rv;
    chk("mem_abort", mem_abort, exp_abort);
    if (mem_abort) n_abort++;
    if (mem_req) n_req_cycles++;
    if (prev_rv && !prev_rr) begin
      chk("rvalid_hold", S_AXI_RVALID, 1'b1);
      chk("rdata_hold", S_AXI_RDATA, prev_rd);
      chk("rresp_hold", S_AXI_RRESP, prev_rs);
    end else if (S_AXI_RVALID && acc_cyc.size() > 0) begin
      last_lat = cyc - acc_cyc[0];
    end
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      if (exp_q.size() == 0) chk("spurious_resp", S_AXI_RVALID, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("rdata", S_AXI_RDATA, e.data);
        chk("rresp", S_AXI_RRESP, e.resp);
        n_resp++;
        if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
      end
    end
    if (be_phase == 0 && mem_req && mem_ready) begin
      if (hit_q.size() == 0) chk("spurious_req", mem_req, 1'b0);
      else begin
        h = hit_q.pop_front();
        chk("mem_addr", mem_addr, h.addr);
        be_addr  = mem_addr;
        be_lat   = h.lat;
        be_phase = 1;
        be_wcnt  = 0;
      end
    end else if (be_phase == 1 && (give_rv || be_wcnt == TO)) begin
      be_phase = 0;
    end
    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      a = ar_pend.pop_front();
      n_accepted++;
      acc_cyc.push_back(cyc);
      if (in_window(a)) begin
        if (plan_lat.size() > 0) lat = plan_lat.pop_front();
        else lat = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(1, TO));
        hit_q.push_back('{a, lat});
        if (lat <= TO) exp_q.push_back('{datafn(a), 2'b00});
        else exp_q.push_back('{32'h0, 2'b10});
      end else begin
        exp_q.push_back('{32'h0, 2'b11});
      end
    end
    prev_rv = S_AXI_RVALID;
    prev_rr = S_AXI_RREADY;
    prev_rd = S_AXI_RDATA;
    prev_rs = S_AXI_RRESP;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int i = 0;
    while ((exp_q.size() > 0 || ar_pend.size() > 0) && i < max_cyc) begin
      step();
      i++;
    end
    chk(tag, exp_q.size() + ar_pend.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_arready", S_AXI_ARREADY, 1'b1);
    chk("rst_rvalid", S_AXI_RVALID, 1'b0);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    chk("rst_rresp", S_AXI_RRESP, 2'b00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_abort", mem_abort, 1'b0);
    rst_n = 1'b1;

    // Single zero-wait read: RVALID four cycles after the AR handshake.
    plan_lat.push_back(1);
    ar_pend.push_back(32'h10);
    drain("t1_drain", 50);
    chk("t1_latency", last_lat, 4);

    // Stalled R channel: one read in flight plus AR_DEPTH queued, then in-order drain.
    base_acc = n_accepted; base_resp = n_resp;
    rready_pct = 0;
    repeat (4) plan_lat.push_back(1);
    ar_pend.push_back(32'h0); ar_pend.push_back(32'h4);
    ar_pend.push_back(32'h8); ar_pend.push_back(32'hC);
    repeat (12) step();
    chk("t2_accepted", n_accepted - base_acc, 3);
    chk("t2_arready_low", S_AXI_ARREADY, 1'b0);
    rready_pct = 100;
    drain("t2_drain", 100);
    chk("t2_resp_count", n_resp - base_resp, 4);

    // Out-of-window read: DECERR without touching the backend.
    base_req = n_req_cycles;
    ar_pend.push_back(32'h2000);
    drain("t3_drain", 50);
    chk("t3_latency", last_lat, 2);
    chk("t3_no_req", n_req_cycles - base_req, 0);

    // Hung backend times out with one abort pulse; the queued read behind it completes.
    base_abort = n_abort;
    plan_lat.push_back(TO + 1); plan_lat.push_back(1);
    ar_pend.push_back(32'h100); ar_pend.push_back(32'h104);
    drain("t4_drain", 100);
    chk("t4_abort_count", n_abort - base_abort, 1);

    // Data on the final WAIT cycle wins; response held while RREADY is low.
    base_abort = n_abort;
    plan_lat.push_back(TO);
    rready_pct = 0;
    ar_pend.push_back(32'h200);
    begin
      int i = 0;
      while (!S_AXI_RVALID && i < 60) begin step(); i++; end
    end
    chk("t5_rvalid_seen", S_AXI_RVALID, 1'b1);
    repeat (5) step();
    rready_pct = 100;
    drain("t5_drain", 50);
    chk("t5_no_abort", n_abort - base_abort, 0);

    // Reset in WAIT with one address still queued: everything drops, nothing is returned.
    plan_lat.push_back(TO + 1); plan_lat.push_back(TO + 1);
    ar_pend.push_back(32'h40); ar_pend.push_back(32'h44);
    begin
      int i = 0;
      while (!(be_phase == 1 && be_wcnt >= 3) && i < 40) begin step(); i++; end
    end
    chk("t6_in_wait", be_wcnt >= 3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", S_AXI_RVALID, 1'b0);
    chk("t6_rst_mem_req", mem_req, 1'b0);
    chk("t6_rst_abort", mem_abort, 1'b0);
    exp_q.delete(); hit_q.delete(); ar_pend.delete(); acc_cyc.delete(); plan_lat.delete();
    be_phase = 0; be_wcnt = 0; prev_rv = 1'b0; prev_rr = 1'b0;
    mem_rvalid = 1'b0; mem_ready = 1'b0; S_AXI_ARVALID = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_arready", S_AXI_ARREADY, 1'b1);
      chk("t6_no_rvalid", S_AXI_RVALID, 1'b0);
      chk("t6_no_req", mem_req, 1'b0);
    end

    // Random traffic with window boundaries, backpressure and stray backend rvalid.
    junk_en = 1'b1; ready_pct = 60; rready_pct = 60;
    ar_pend.push_back(32'h0000_0FFC);
    ar_pend.push_back(32'h0000_1000);
    ar_pend.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7) ar_pend.push_back(32'($urandom_range(0, 1023)) << 2);
      else ar_pend.push_back(32'h0000_1000 + (32'($urandom_range(0, 65535)) << 2));
    end
    base_resp = n_resp;
    drain("rand_drain", 6000);
    chk("rand_resp_count", n_resp - base_resp, 63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
